// File: rtl/multiplicador_pkg.sv
// Shared types and constants for the signed-magnitude multiplier stage.
package multiplicador_pkg;

   typedef enum logic [1:0] {
      IDLE,
      MUL,
      CONV,
      FIN
   } mult_state_t;

   localparam int unsigned W_DEF  = 8;
   localparam int unsigned ND_DEF = 5;

   // Counter width large enough to count 0..2w-1.
   function automatic int unsigned cnt_width(input int unsigned w);
      return $clog2(2 * w);
   endfunction

endpackage

// File: rtl/module_bin2bcd.sv
// Serial double-dabble converter: loads on start, shifts 2W times, pulses ready_c
// in the cycle of the last shift so the caller can advance on that same edge.
module module_bin2bcd
   import multiplicador_pkg::*;
#(
   parameter int unsigned W  = W_DEF,
   parameter int unsigned ND = ND_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [2*W-1:0]    bin,
   output logic [4*ND-1:0]   bcd,
   output logic              ready_c
);

   localparam int unsigned PW = 2 * W;
   localparam int unsigned BW = 4 * ND;
   localparam int unsigned SW = BW + PW;
   localparam int unsigned CW = cnt_width(W);

   logic [SW-1:0] sr_q, sr_d;
   logic [SW-1:0] dab;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          active_q, active_d;

   // Shift register, shift counter and activity flag.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sr_q     <= '0;
         cnt_q    <= '0;
         active_q <= 1'b0;
      end else begin
         sr_q     <= sr_d;
         cnt_q    <= cnt_d;
         active_q <= active_d;
      end
   end

   // One double-dabble step per cycle: correct digits >= 5, then shift left.
   always_comb begin
      sr_d     = sr_q;
      cnt_d    = cnt_q;
      active_d = active_q;
      dab      = sr_q;
      ready_c  = active_q && (cnt_q == CW'(PW - 1));

      for (int unsigned i = 0; i < ND; i++) begin
         if (dab[PW + 4*i +: 4] >= 4'd5) begin
            dab[PW + 4*i +: 4] = dab[PW + 4*i +: 4] + 4'd3;
         end
      end

      if (start) begin
         sr_d     = {BW'(0), bin};
         cnt_d    = '0;
         active_d = 1'b1;
      end else if (active_q) begin
         sr_d  = dab << 1;
         cnt_d = cnt_q + CW'(1);
         if (ready_c) begin
            active_d = 1'b0;
         end
      end
   end

   assign bcd = sr_q[SW-1 -: BW];

endmodule

// File: rtl/module_multiplicador.sv
// Sequential signed-magnitude multiplier: shift-add product, then BCD conversion.
module module_multiplicador
   import multiplicador_pkg::*;
#(
   parameter int unsigned W  = W_DEF,
   parameter int unsigned ND = ND_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              valid,
   input  logic [W-1:0]      numero1,
   input  logic [W-1:0]      numero2,
   input  logic              signo1,
   input  logic              signo2,
   output logic              busy,
   output logic              done,
   output logic [2*W-1:0]    producto,
   output logic              signo_res,
   output logic [4*ND-1:0]   bcd
);

   localparam int unsigned PW = 2 * W;
   localparam int unsigned BW = 4 * ND;
   localparam int unsigned CW = cnt_width(W);

   mult_state_t   state_q, state_d;
   logic          valid_q, valid_d;
   logic [PW-1:0] mcand_q, mcand_d;
   logic [W-1:0]  mplier_q, mplier_d;
   logic [PW-1:0] acc_q, acc_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          s1_q, s1_d;
   logic          s2_q, s2_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic [PW-1:0] producto_q, producto_d;
   logic [BW-1:0] bcd_q, bcd_d;
   logic          signo_res_q, signo_res_d;

   logic          conv_start_c;
   logic          conv_ready_c;
   logic [BW-1:0] conv_bcd;

   // Converter is started with the final accumulator value on the last MUL edge.
   module_bin2bcd #(
      .W  (W),
      .ND (ND)
   ) u_bin2bcd (
      .clk     (clk),
      .rst     (rst),
      .start   (conv_start_c),
      .bin     (acc_d),
      .bcd     (conv_bcd),
      .ready_c (conv_ready_c)
   );

   // State and datapath registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         valid_q     <= 1'b0;
         mcand_q     <= '0;
         mplier_q    <= '0;
         acc_q       <= '0;
         cnt_q       <= '0;
         s1_q        <= 1'b0;
         s2_q        <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         producto_q  <= '0;
         bcd_q       <= '0;
         signo_res_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         valid_q     <= valid_d;
         mcand_q     <= mcand_d;
         mplier_q    <= mplier_d;
         acc_q       <= acc_d;
         cnt_q       <= cnt_d;
         s1_q        <= s1_d;
         s2_q        <= s2_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         producto_q  <= producto_d;
         bcd_q       <= bcd_d;
         signo_res_q <= signo_res_d;
      end
   end

   // Next-state and datapath logic; valid_q tracks valid in every state.
   always_comb begin
      state_d      = state_q;
      valid_d      = valid;
      mcand_d      = mcand_q;
      mplier_d     = mplier_q;
      acc_d        = acc_q;
      cnt_d        = cnt_q;
      s1_d         = s1_q;
      s2_d         = s2_q;
      busy_d       = busy_q;
      done_d       = 1'b0;
      producto_d   = producto_q;
      bcd_d        = bcd_q;
      signo_res_d  = signo_res_q;
      conv_start_c = 1'b0;

      case (state_q)
         IDLE: begin
            if (valid && !valid_q) begin
               mcand_d  = {W'(0), numero1};
               mplier_d = numero2;
               s1_d     = signo1;
               s2_d     = signo2;
               acc_d    = '0;
               cnt_d    = '0;
               busy_d   = 1'b1;
               state_d  = MUL;
            end
         end
         MUL: begin
            if (mplier_q[0]) begin
               acc_d = acc_q + mcand_q;
            end
            mcand_d  = mcand_q << 1;
            mplier_d = mplier_q >> 1;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               conv_start_c = 1'b1;
               state_d      = CONV;
            end
         end
         CONV: begin
            if (conv_ready_c) begin
               state_d = FIN;
            end
         end
         FIN: begin
            producto_d  = acc_q;
            bcd_d       = conv_bcd;
            signo_res_d = (s1_q ^ s2_q) & (|acc_q);
            done_d      = 1'b1;
            busy_d      = 1'b0;
            state_d     = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy      = busy_q;
   assign done      = done_q;
   assign producto  = producto_q;
   assign bcd       = bcd_q;
   assign signo_res = signo_res_q;

endmodule

// File: doc/module_multiplicador.md
# module_multiplicador

Sequential signed-magnitude multiplier stage fed directly by `module_control`. It takes the two assembled operands and their sign bits when `valid` rises, multiplies the magnitudes with an iterative shift-add datapath, and converts the binary product to packed BCD for the display stage. It reports completion with a one-cycle `done` pulse and holds the result until the next operation finishes.

## Interface
Parameters:
- `W`, default 8: operand magnitude width.
- `ND`, default 5: number of BCD output digits; must satisfy 10^ND > (2^W−1)^2.

Ports:
- `clk`  in  1  system clock; all state updates on its rising edge.
- `rst`  in  1  asynchronous, active-low reset.
- `valid`  in  1  operands-ready level from `module_control`; a 0→1 transition starts an operation.
- `numero1`  in  W  operand A magnitude, unsigned binary.
- `numero2`  in  W  operand B magnitude, unsigned binary.
- `signo1`  in  1  sign of A; 1 means negative.
- `signo2`  in  1  sign of B; 1 means negative.
- `busy`  out  1  high from the start edge until `done` is issued.
- `done`  out  1  one-cycle completion pulse.
- `producto`  out  2W  unsigned product magnitude.
- `signo_res`  out  1  result sign.
- `bcd`  out  4·ND  packed BCD of `producto`; the least significant digit is in [3:0].

## Operation
- Reset (`rst`=0, asynchronous) puts the block in IDLE and clears every register, including `valid_q`. All outputs are 0 while reset is held and after release.
- State machine: IDLE → MUL → CONV → FIN → IDLE.
- **IDLE**
  - `valid_q` registers `valid` on every edge.
  - On an edge where `valid`=1 and `valid_q`=0, the block latches `numero1`, `numero2`, `signo1` and `signo2`.
  - It clears the accumulator (2W bits) and the counter, sets `busy`, and goes to MUL.
  - Holding `valid` high does not retrigger the block.
- **MUL**
  - Runs exactly W cycles, using counter 0..W−1.
  - Each cycle: if multiplier bit 0 is 1, add the multiplicand to the accumulator (2W-bit add, no overflow possible).
  - Then shift the multiplicand left by 1 and the multiplier right by 1.
  - After the W-th cycle, go to CONV.
- **CONV**
  - Double-dabble over 2W cycles.
  - Each cycle: first add 3 to every BCD nibble that is ≥5, then shift the {bcd, binary} register left by 1.
  - After 2W cycles, go to FIN.
- **FIN**
  - Load `producto`, `bcd` and `signo_res` in one edge.
  - `signo_res` = `signo1` XOR `signo2`, except that it is forced to 0 when the product is 0 (no negative zero).
  - Assert `done` for this cycle, clear `busy`, and return to IDLE.
- A `valid` rising edge while `busy`=1 is ignored. `valid_q` keeps tracking `valid` in every state, so a rise that occurs during an operation is never seen later.
- Operand changes after the start edge have no effect on the operation in progress.
- Reset asserted mid-operation aborts the operation immediately. Outputs return to 0, and no `done` is produced.

## Timing
- Start edge S is the edge where IDLE sees the `valid` rise. `busy` is high from S.
- Registered outputs (`producto`, `bcd`, `signo_res`) update and `done` rises at edge S+W+2W+1. With defaults this is S+25.
- `done` falls at S+26. A new start can be accepted at S+26 at the earliest, because `valid` must first return low and then rise again.
- `busy` falls at the same edge where `done` rises.
- Outputs hold their values between completions. There is no combinational path from any input to any output.

## Structure
- Package `multiplicador_pkg` holds:
  - the state enum `mult_state_t` {IDLE, MUL, CONV, FIN};
  - default width constants `W_DEF`=8 and `ND_DEF`=5;
  - a function returning the counter width, `$clog2(2W)`.
- Sub-module `module_bin2bcd`:
  - serial double-dabble converter with parameters `W` and `ND`;
  - ports: start pulse, 2W-bit binary input, `bcd` output, one-cycle `ready` pulse;
  - instantiated once. The top-level FSM waits in CONV for its `ready`.

## Test plan
- 99 (+) × 15 (−), `valid` held high afterwards → after 25 cycles `producto`=1485, `bcd`=20'h01485, `signo_res`=1, one `done` pulse, and no second `done` while `valid` stays high.
- 99 (+) × 99 (+) → `producto`=9801, `bcd`=20'h09801, `signo_res`=0.
- 0 (−) × 7 (+) → `producto`=0, `bcd`=0, `signo_res`=0 (negative-zero suppression).
- 255 (−) × 255 (−) → `producto`=65025, `bcd`=20'h65025, `signo_res`=0 (full-width boundary).
- Start 12×12, pulse `valid` low then high at S+5, change operands to 3×3 → result is 144; the second rise is ignored and only one `done` occurs.
- Start 50×50, assert `rst`=0 at S+10 for 2 cycles → all outputs 0 and no `done`. A new start with 6 (−) × 7 (+) then gives 42, `signo_res`=1, 25 cycles after its start edge.
